// File: rtl/shift_arb_pkg.sv
// Shared constants and types for the two-requester shift arbiter.
// Optional feature macro: SHIFT_ARB_RR_EN (round-robin grant on ties).
package shift_arb_pkg;

  localparam int unsigned NREQ  = 2;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned AMT_W = 3;
  localparam int unsigned OP_W  = 2;

  localparam logic [OP_W-1:0] SHIFT_SLL  = 2'b00;
  localparam logic [OP_W-1:0] SHIFT_RSVD = 2'b01;
  localparam logic [OP_W-1:0] SHIFT_SRA  = 2'b10;
  localparam logic [OP_W-1:0] SHIFT_SRL  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/mips8_shift.sv
// Combinational 8-bit barrel shifter: SLL/SRL zero-fill, SRA sign-fill,
// reserved op passes the operand through.
module mips8_shift
  import shift_arb_pkg::*;
(
  input  logic [WIDTH-1:0] i_data,
  input  logic [AMT_W-1:0] i_amt,
  input  logic [OP_W-1:0]  i_op,
  output logic [WIDTH-1:0] o_result_c
);

  // Select the shift flavour by op code.
  always_comb begin
    o_result_c = i_data;
    case (i_op)
      SHIFT_SLL: o_result_c = i_data << i_amt;
      SHIFT_SRL: o_result_c = i_data >> i_amt;
      SHIFT_SRA: o_result_c = WIDTH'($signed(i_data) >>> i_amt);
      default:   o_result_c = i_data;
    endcase
  end

endmodule

// File: rtl/shift_arb_grant.sv
// One-hot grant for two requesters.
// SHIFT_ARB_RR_EN defined: ties go to the index that did not win last.
// Undefined: requester 0 has fixed priority.
module shift_arb_grant
  import shift_arb_pkg::*;
(
  input  logic [NREQ-1:0] i_req_valid,
`ifdef SHIFT_ARB_RR_EN
  input  logic            i_rr_last,
`endif
  output logic [NREQ-1:0] o_grant_c
);

`ifdef SHIFT_ARB_RR_EN
  // Round-robin on a tie, otherwise grant the lone requester.
  always_comb begin
    o_grant_c = '0;
    if (&i_req_valid) begin
      o_grant_c = i_rr_last ? 2'b01 : 2'b10;
    end else begin
      o_grant_c = i_req_valid;
    end
  end
`else
  // Fixed priority: requester 0 first.
  always_comb begin
    o_grant_c = '0;
    if (i_req_valid[0]) begin
      o_grant_c = 2'b01;
    end else if (i_req_valid[1]) begin
      o_grant_c = 2'b10;
    end
  end
`endif

endmodule

// File: rtl/shift_arbiter.sv
// Shares one mips8_shift unit between two valid/ready requesters.
// One op in flight: IDLE (accept) -> EXEC (shift, capture) -> RESP (hold until taken).
// Optional feature macro: SHIFT_ARB_RR_EN (round-robin instead of fixed priority).
module shift_arbiter
  import shift_arb_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*WIDTH-1:0]   req_data,
  input  logic [NREQ*AMT_W-1:0]   req_amt,
  input  logic [NREQ*OP_W-1:0]    req_op,
  output logic [NREQ-1:0]         rsp_valid,
  input  logic [NREQ-1:0]         rsp_ready,
  output logic [WIDTH-1:0]        rsp_data
);

  state_t           r_state;
  logic [WIDTH-1:0] r_data;
  logic [AMT_W-1:0] r_amt;
  logic [OP_W-1:0]  r_op;
  logic             r_owner;
  logic [NREQ-1:0]  r_rsp_valid;
  logic [WIDTH-1:0] r_rsp_data;
`ifdef SHIFT_ARB_RR_EN
  logic             r_rr_last;
`endif

  logic [NREQ-1:0]  w_grant;
  logic             w_sel;
  logic             w_accept;
  logic [WIDTH-1:0] w_sel_data;
  logic [AMT_W-1:0] w_sel_amt;
  logic [OP_W-1:0]  w_sel_op;
  logic [WIDTH-1:0] w_shift_result;

  shift_arb_grant u_grant (
    .i_req_valid (req_valid),
`ifdef SHIFT_ARB_RR_EN
    .i_rr_last   (r_rr_last),
`endif
    .o_grant_c   (w_grant)
  );

  // The shifter only ever sees the operand registers.
  mips8_shift u_shift (
    .i_data     (r_data),
    .i_amt      (r_amt),
    .i_op       (r_op),
    .o_result_c (w_shift_result)
  );

  // Ready is offered to the granted requester only while idle and out of reset.
  always_comb begin
    req_ready = '0;
    if ((r_state == ST_IDLE) && !rst) begin
      req_ready = w_grant;
    end
  end

  // Accept decode and operand mux for the granted requester.
  always_comb begin
    w_accept   = (r_state == ST_IDLE) && (|w_grant);
    w_sel      = w_grant[1];
    w_sel_data = req_data[WIDTH-1:0];
    w_sel_amt  = req_amt[AMT_W-1:0];
    w_sel_op   = req_op[OP_W-1:0];
    if (w_sel) begin
      w_sel_data = req_data[2*WIDTH-1:WIDTH];
      w_sel_amt  = req_amt[2*AMT_W-1:AMT_W];
      w_sel_op   = req_op[2*OP_W-1:OP_W];
    end
  end

  // Control FSM with registered operands, owner and response.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_data      <= '0;
      r_amt       <= '0;
      r_op        <= '0;
      r_owner     <= 1'b0;
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
`ifdef SHIFT_ARB_RR_EN
      r_rr_last   <= 1'b1;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_data    <= w_sel_data;
            r_amt     <= w_sel_amt;
            r_op      <= w_sel_op;
            r_owner   <= w_sel;
`ifdef SHIFT_ARB_RR_EN
            r_rr_last <= w_sel;
`endif
            r_state   <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_rsp_data  <= w_shift_result;
          r_rsp_valid <= r_owner ? 2'b10 : 2'b01;
          r_state     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready[r_owner]) begin
            r_rsp_valid <= '0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_rsp_valid <= '0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter: single ops, SRA/SRL, tie arbitration,
// backpressure, mid-operation reset and a full data/amount/op sweep.
module tb_shift_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [15:0] req_data;
  logic [5:0]  req_amt;
  logic [3:0]  req_op;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [7:0]  rsp_data;

  int n_checks = 0;
  int n_errors = 0;

  shift_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_amt   (req_amt),
    .req_op    (req_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Independent reference: shift inside a 16-bit window with explicit fill.
  function automatic logic [7:0] golden(input logic [7:0] d, input logic [2:0] a, input logic [1:0] o);
    logic [15:0] ext;
    case (o)
      2'b00:   begin ext = {8'h00, d} << a;      return ext[7:0]; end
      2'b11:   begin ext = {8'h00, d} >> a;      return ext[7:0]; end
      2'b10:   begin ext = {{8{d[7]}}, d} >> a;  return ext[7:0]; end
      default: return d;
    endcase
  endfunction

  // Present a request on port p and wait (bounded) for it to be accepted.
  // Returns at posedge+1 of the EXEC cycle.
  task automatic send(input int p, input logic [7:0] d, input logic [2:0] a, input logic [1:0] o);
    logic acc;
    req_data[p*8 +: 8] = d;
    req_amt[p*3 +: 3]  = a;
    req_op[p*2 +: 2]   = o;
    req_valid[p]       = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      acc = req_ready[p];
      @(posedge clk); #1;
    end
    req_valid[p] = 1'b0;
    if (!acc) check_eq("accept_timeout", 32'(acc), 32'd1);
  endtask

  // Check two-cycle latency and one-hot response, capture data, let it drain.
  task automatic wait_rsp(input int p, output logic [7:0] res);
    logic [1:0] exp_v;
    exp_v = (p == 1) ? 2'b10 : 2'b01;
    @(negedge clk);
    check_eq("exec_no_rsp", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("rsp_valid_onehot", 32'(rsp_valid), 32'(exp_v));
    check_eq("resp_req_ready", 32'(req_ready), 32'd0);
    res = rsp_data;
    @(posedge clk); #1;
  endtask

  logic [1:0] ops [3] = '{2'b00, 2'b11, 2'b10};

  initial begin
    logic [7:0] res;
    logic [1:0] g;
    logic [1:0] exp_g;
    logic [7:0] hold_data;
    int p;

    rst       = 1'b1;
    req_valid = 2'b11;
    req_data  = '0;
    req_amt   = '0;
    req_op    = '0;
    rsp_ready = 2'b11;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("reset_rsp_data", 32'(rsp_data), 32'd0);
    check_eq("reset_req_ready", 32'(req_ready), 32'd0);
    req_valid = 2'b00;
    @(posedge clk); #1;
    rst = 1'b0;

    // Single op on r0: 0x81 SLL 1 -> 0x02.
    send(0, 8'h81, 3'd1, 2'b00);
    wait_rsp(0, res);
    check_eq("sll_81_1", 32'(res), 32'h02);

    // r1 SRA then SRL.
    send(1, 8'h90, 3'd2, 2'b10);
    wait_rsp(1, res);
    check_eq("sra_90_2", 32'(res), 32'hE4);
    send(1, 8'h90, 3'd1, 2'b11);
    wait_rsp(1, res);
    check_eq("srl_90_1", 32'(res), 32'h48);

    // amt=0 echoes data.
    send(0, 8'hA5, 3'd0, 2'b10);
    wait_rsp(0, res);
    check_eq("sra_amt0_echo", 32'(res), 32'hA5);

    // Backpressure: owner r0 holds rsp_ready low, r1's rsp_ready high is ignored.
    rsp_ready = 2'b10;
    send(0, 8'h3C, 3'd3, 2'b11);
    @(negedge clk);
    @(posedge clk); #1;
    req_data[15:8] = 8'h11;
    req_amt[5:3]   = 3'd1;
    req_op[3:2]    = 2'b00;
    req_valid[1]   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      check_eq("bp_rsp_data", 32'(rsp_data), 32'h07);
      check_eq("bp_req_ready", 32'(req_ready), 32'd0);
      @(posedge clk); #1;
    end
    rsp_ready = 2'b11;
    @(negedge clk);
    check_eq("bp_release_same_cycle", 32'(rsp_valid), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("bp_idle_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("bp_idle_req_ready", 32'(req_ready), 32'd2);
    req_valid = 2'b00;
    @(posedge clk); #1;

    // Reset during EXEC drops the op.
    send(0, 8'h55, 3'd1, 2'b00);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_exec_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_exec_rsp_data", 32'(rsp_data), 32'd0);
    check_eq("rst_exec_req_ready", 32'(req_ready), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check_eq("rst_no_stale_rsp", 32'(rsp_valid), 32'd0);
    end
    @(posedge clk); #1;

    // Tie: both valid held for 6 ops, starting straight after reset.
    req_data  = {8'h80, 8'h01};
    req_amt   = {3'd1, 3'd1};
    req_op    = {2'b11, 2'b00};
    req_valid = 2'b11;
    for (int k = 0; k < 6; k++) begin
`ifdef SHIFT_ARB_RR_EN
      exp_g = k[0] ? 2'b10 : 2'b01;
`else
      exp_g = 2'b01;
`endif
      @(negedge clk);
      g = req_ready;
      check_eq($sformatf("tie_grant_%0d", k), 32'(g), 32'(exp_g));
      @(posedge clk); #1;
      @(negedge clk);
      check_eq("tie_exec_req_ready", 32'(req_ready), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      check_eq("tie_rsp_valid", 32'(rsp_valid), 32'(exp_g));
      check_eq("tie_rsp_data", 32'(rsp_data), (exp_g == 2'b01) ? 32'h02 : 32'h40);
      @(posedge clk); #1;
    end
    // Once r0 drops, r1 is served.
    req_valid = 2'b10;
    @(negedge clk);
    check_eq("lone_r1_grant", 32'(req_ready), 32'd2);
    req_valid = 2'b00;
    @(posedge clk); #1;

    // Full sweep, port alternating with data/amount parity.
    for (int o = 0; o < 3; o++) begin
      for (int a = 0; a < 8; a++) begin
        for (int d = 0; d < 256; d++) begin
          p = (d ^ a) & 1;
          send(p, 8'(d), 3'(a), ops[o]);
          wait_rsp(p, res);
          check_eq($sformatf("sweep_d%02h_a%0d_op%0d", d, a, ops[o]),
                   32'(res), 32'(golden(8'(d), 3'(a), ops[o])));
        end
      end
    end

    hold_data = rsp_data;
    @(negedge clk);
    check_eq("final_idle_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("final_rsp_data_hold", 32'(rsp_data), 32'(hold_data));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
